// File: rtl/line_fill_engine_if.sv
// rtl/line_fill_engine_if.sv - miss request, line response and memory port bundle for line_fill_engine
interface line_fill_engine_if #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int LW = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [AW-1:0]      req_addr;
  logic               req_wb;
  logic [AW-1:0]      req_wb_addr;
  logic [LW*DW-1:0]   req_wb_data;
  logic               resp_valid;
  logic               resp_ready;
  logic [LW*DW-1:0]   resp_data;
  logic [AW-1:0]      fetch_mem_raddr;
  logic               fetch_mem_ren;
  logic               fetch_mem_rready;
  logic [DW-1:0]      fetch_mem_rdata;
  logic               fetch_mem_rdata_valid;
  logic [AW-1:0]      fetch_mem_waddr;
  logic               fetch_mem_wen;
  logic               fetch_mem_wready;
  logic [DW-1:0]      fetch_mem_wdata;

  modport master (
    input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
    input  fetch_mem_rready, fetch_mem_rdata, fetch_mem_rdata_valid, fetch_mem_wready,
    output req_ready, resp_valid, resp_data,
    output fetch_mem_raddr, fetch_mem_ren, fetch_mem_waddr, fetch_mem_wen, fetch_mem_wdata
  );

  modport slave (
    output req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
    output fetch_mem_rready, fetch_mem_rdata, fetch_mem_rdata_valid, fetch_mem_wready,
    input  req_ready, resp_valid, resp_data,
    input  fetch_mem_raddr, fetch_mem_ren, fetch_mem_waddr, fetch_mem_wen, fetch_mem_wdata
  );
endinterface

// File: rtl/line_fill_engine.sv
// rtl/line_fill_engine.sv - victim writeback then line refill engine for the fetch_mem port
// Optional LINE_FILL_CWF_EN: critical-word-first read order (wraps within the line).
module line_fill_engine #(
  parameter int mem_depth  = 32,
  parameter int data_width = 32,
  parameter int line_words = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  line_fill_engine_if.master bus
);
  localparam int AW = $clog2(mem_depth);
  localparam int OW = $clog2(line_words);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_RD, S_DRAIN, S_RESP} state_t;

  state_t                        r_state, w_next;
  logic [AW-1:0]                 r_base, r_wb_base;
  logic [OW-1:0]                 r_beat, r_pipe_idx;
  logic                          r_pipe_vld;
  logic [OW:0]                   r_cap_cnt;
  logic [line_words*data_width-1:0] r_wb_data, r_resp_data;
  logic [OW-1:0]                 w_start, w_rd_idx;
  logic                          w_req_hs, w_wr_hs, w_rd_hs, w_capture, w_last_beat, w_cap_done;

  assign w_req_hs    = bus.req_valid & bus.req_ready;
  assign w_wr_hs     = bus.fetch_mem_wen & bus.fetch_mem_wready;
  assign w_rd_hs     = bus.fetch_mem_ren & bus.fetch_mem_rready;
  assign w_capture   = bus.fetch_mem_rdata_valid & r_pipe_vld;
  assign w_last_beat = (r_beat == OW'(line_words - 1));
  assign w_cap_done  = ((r_cap_cnt + (OW+1)'(w_capture)) == (OW+1)'(line_words));
  assign w_rd_idx    = w_start + r_beat;

`ifdef LINE_FILL_CWF_EN
  logic [OW-1:0] r_start;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_start <= '0;
    else if (w_req_hs)
      r_start <= bus.req_addr[OW-1:0];
  end
  assign w_start = r_start;
`else
  assign w_start = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_hs) w_next = bus.req_wb ? S_WB : S_RD;
      S_WB:    if (w_wr_hs && w_last_beat) w_next = S_RD;
      S_RD:    if (w_rd_hs && w_last_beat) w_next = S_DRAIN;
      S_DRAIN: if (w_cap_done) w_next = S_RESP;
      S_RESP:  if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.fetch_mem_ren = 1'b0;
    bus.fetch_mem_wen = 1'b0;
    case (r_state)
      S_IDLE:  bus.req_ready     = 1'b1;
      S_WB:    bus.fetch_mem_wen = 1'b1;
      S_RD:    bus.fetch_mem_ren = 1'b1;
      S_RESP:  bus.resp_valid    = 1'b1;
      default: ;
    endcase
  end

  // One beat counter serves both phases; it wraps to 0 after the last writeback beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_wb_base   <= '0;
      r_wb_data   <= '0;
      r_beat      <= '0;
      r_cap_cnt   <= '0;
      r_pipe_vld  <= 1'b0;
      r_pipe_idx  <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_req_hs) begin
        r_base    <= bus.req_addr & ~AW'(line_words - 1);
        r_wb_base <= bus.req_wb_addr & ~AW'(line_words - 1);
        r_wb_data <= bus.req_wb_data;
        r_beat    <= '0;
        r_cap_cnt <= '0;
      end else begin
        if (w_wr_hs || w_rd_hs)
          r_beat <= r_beat + 1'b1;
        if (w_capture)
          r_cap_cnt <= r_cap_cnt + 1'b1;
      end
      r_pipe_vld <= w_rd_hs;
      if (w_rd_hs)
        r_pipe_idx <= w_rd_idx;
      if (w_capture)
        r_resp_data[r_pipe_idx*data_width +: data_width] <= bus.fetch_mem_rdata;
    end
  end

  assign bus.fetch_mem_raddr = r_base | AW'(w_rd_idx);
  assign bus.fetch_mem_waddr = r_wb_base | AW'(r_beat);
  assign bus.fetch_mem_wdata = r_wb_data[r_beat*data_width +: data_width];
  assign bus.resp_data       = r_resp_data;

endmodule
